// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtractive GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_sub_cmp.sv
// Combinational compare/subtract datapath for one subtractive GCD step.
module gcd_sub_cmp
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] a_minus_b,
  output logic [WIDTH-1:0] b_minus_a
);

  assign a_gt_b    = (a > b);
  assign a_eq_b    = (a == b);
  assign a_zero    = (a == '0);
  assign b_zero    = (b == '0);
  assign a_minus_b = WIDTH'(a - b);
  assign b_minus_a = WIDTH'(b - a);

endmodule : gcd_sub_cmp

// File: rtl/gcd_engine_param.sv
// Subtractive GCD engine: serial A/B load over one handshaked bus, result held until next start.
// Define GCD_CYCLE_COUNT_EN to add the 'cycles' output (subtraction count of the last operation).
module gcd_engine_param
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_err
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_gt_b, a_eq_b, a_zero, b_zero;
  logic [WIDTH-1:0] a_minus_b, b_minus_a;
  logic             beat_c;
  logic             finish_c;

  gcd_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .a         (a_q),
    .b         (b_q),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_minus_b (a_minus_b),
    .b_minus_a (b_minus_a)
  );

  assign beat_c   = in_valid && in_ready;
  assign finish_c = a_zero || b_zero || a_eq_b;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = LOAD_A;
      LOAD_A:  if (beat_c)   state_d = LOAD_B;
      LOAD_B:  if (beat_c)   state_d = CALC;
      CALC:    if (finish_c) state_d = DONE;
      DONE:    if (start)    state_d = LOAD_A;
      default:               state_d = IDLE;
    endcase
  end

  // Handshake/status decode from the registered state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      LOAD_A, LOAD_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      CALC:    busy = 1'b1;
      default: ;
    endcase
  end

  // Operand registers and held result; the zero cases fold into "result = A unless A is 0"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      done     <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: if (beat_c) a_q <= data_in;
        LOAD_B: if (beat_c) b_q <= data_in;
        CALC: begin
          if (finish_c) begin
            done     <= 1'b1;
            zero_err <= a_zero && b_zero;
            result   <= a_zero ? b_q : a_q;
          end else if (a_gt_b) begin
            a_q <= a_minus_b;
          end else begin
            b_q <= b_minus_a;
          end
        end
        DONE: begin
          if (start) begin
            done     <= 1'b0;
            zero_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  // Subtraction counter: cleared as CALC is entered, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
    end else if (state_q == LOAD_B && beat_c) begin
      cycles <= '0;
    end else if (state_q == CALC && !finish_c && cycles != {WIDTH{1'b1}}) begin
      cycles <= WIDTH'(cycles + 1'b1);
    end
  end
`endif

endmodule : gcd_engine_param

// File: tb/tb_gcd_engine_param.sv
// Scoreboard bench for gcd_engine_param (WIDTH=8) against a Euclid-division reference model.
module tb_gcd_engine_param;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero_err;
`ifdef GCD_CYCLE_COUNT_EN
  logic [W-1:0] cycles;
`endif

  gcd_engine_param #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero_err (zero_err)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned res;
    int unsigned zerr;
    int unsigned n;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  logic        done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: GCD by Euclid division; subtraction count = sum of quotients minus one
  task automatic ref_model(input int unsigned a, input int unsigned b,
                           output int unsigned res, output int unsigned zerr,
                           output int unsigned n);
    int unsigned x, y, r;
    zerr = 0;
    n    = 0;
    if (a == 0 && b == 0) begin
      res  = 0;
      zerr = 1;
    end else if (a == 0) begin
      res = b;
    end else if (b == 0) begin
      res = a;
    end else begin
      x = (a > b) ? a : b;
      y = (a > b) ? b : a;
      while (y != 0) begin
        n += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      res = x;
      n   = n - 1;
      if (n > (1 << W) - 1) n = (1 << W) - 1;
    end
  endtask

  // Monitor: pop and compare on each rising edge of done
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_d = 1'b0;
    end else begin
      if (done && !done_d) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("zero_err", zero_err, e.zerr);
          chk("latency", cyc, e.done_cyc);
`ifdef GCD_CYCLE_COUNT_EN
          chk("cycles", cycles, e.n);
`endif
        end
      end
      done_d = done;
    end
  end

  // Present one beat at a negedge; returns at the negedge after it was accepted
  task automatic send_beat(input int unsigned d, input bit is_b, input int unsigned a_val,
                           input bit push);
    bit          ok = 0;
    int unsigned idx = 0;
    exp_t        e;
    in_valid = 1'b1;
    data_in  = W'(d);
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        idx = cyc + 1;
        ok  = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    if (ok && is_b && push) begin
      ref_model(a_val, d, e.res, e.zerr, e.n);
      e.done_cyc = idx + e.n + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = W'($urandom);
  endtask

  task automatic run_op(input int unsigned a, input int unsigned b,
                        input int unsigned gap_b, input bit push);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_beat(a, 1'b0, 0, push);
    for (int i = 0; i < int'(gap_b); i++) begin
      chk("in_ready_hold_load_b", in_ready, 1);
      chk("busy_hold_load_b", busy, 1);
      @(negedge clk);
    end
    send_beat(b, 1'b1, a, push);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int unsigned ra, rb, prev;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero_err", zero_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("rst_cycles", cycles, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(65, 39, 0, 1); wait_done();
    run_op(48, 18, 0, 1); wait_done();
    run_op(0, 27, 0, 1);  wait_done();
    run_op(0, 0, 0, 1);   wait_done();
    run_op(27, 0, 0, 1);  wait_done();

    // start in DONE clears done but keeps result until the next finish
    prev  = result;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared_by_start", done, 0);
    chk("result_held_after_start", result, prev);
    chk("in_ready_load_a", in_ready, 1);
    send_beat(1, 1'b0, 0, 1);
    send_beat(255, 1'b1, 1, 1);
    // start pulse while computing must be ignored
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    chk("start_ignored_in_ready", in_ready, 0);
    chk("start_ignored_result", result, prev);
    wait_done();

    run_op(255, 255, 0, 1); wait_done();
    run_op(91, 35, 3, 1);   wait_done();

    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      run_op(ra, rb, $urandom_range(0, 2), 1);
      wait_done();
    end

    // asynchronous reset in the middle of a long calculation
    run_op(1, 254, 0, 0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_in_ready", in_ready, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("async_rst_cycles", cycles, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(65, 39, 0, 1); wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gcd_engine_param
